// File: rtl/piso_pkg.sv
// rtl/piso_pkg.sv - shared types and constants for the piso_tx transmitter
// Contents: piso_state_t FSM encoding, PISO_DEF_WIDTH default word width.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } piso_state_t;

    localparam int PISO_DEF_WIDTH = 4;

endpackage

// File: rtl/piso_tx_if.sv
// rtl/piso_tx_if.sv - load handshake and serial output bundle for piso_tx
// Signals: load_valid/load_ready/data_in (word load handshake),
//          ser_out/shift_en (serial link to receiver), busy, word_done.
// Modports: slave = the transmitter, master = the word source / observer.
interface piso_tx_if
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEF_WIDTH
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data_in;
    logic             ser_out;
    logic             shift_en;
    logic             busy;
    logic             word_done;

    modport slave (
        input  load_valid,
        input  data_in,
        output load_ready,
        output ser_out,
        output shift_en,
        output busy,
        output word_done
    );

    modport master (
        output load_valid,
        output data_in,
        input  load_ready,
        input  ser_out,
        input  shift_en,
        input  busy,
        input  word_done
    );
endinterface

// File: rtl/piso_hold.sv
// rtl/piso_hold.sv - one-entry hold buffer for the next word to transmit
// Ports: clk, rst (async, active-high), wr_en/wr_data (capture a word),
//        rd_en (release the held word), rd_data, hold_valid.
module piso_hold
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             hold_valid
);

    logic [WIDTH-1:0] hold_data;

    // The transmitter never writes and reads in the same cycle: it only
    // accepts into the buffer while the buffer is empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_data  <= '0;
            hold_valid <= 1'b0;
        end else if (wr_en) begin
            hold_data  <= wr_data;
            hold_valid <= 1'b1;
        end else if (rd_en) begin
            hold_valid <= 1'b0;
        end
    end

    assign rd_data = hold_data;

endmodule

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter, LSB first
// Ports: clk, rst (async, active-high), bus (piso_tx_if.slave):
//        load_valid/load_ready/data_in word handshake, ser_out/shift_en to
//        the serial receiver, busy (shifting or pending), word_done pulse.
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH = PISO_DEF_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    piso_tx_if.slave   bus
);

    localparam int CNT_W = $clog2(WIDTH);

    piso_state_t      state;
    logic [WIDTH-1:0] sreg;
    logic [CNT_W-1:0] cnt;
    logic             word_done_r;

    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic             hold_wr;
    logic             hold_rd;

    logic             accept;
    logic             cnt_last;

    assign bus.load_ready = (state == IDLE) || !hold_valid;
    assign accept         = bus.load_valid && bus.load_ready;
    assign cnt_last       = (cnt == CNT_W'(WIDTH - 1));

    // An accept on the final-bit edge with an empty buffer goes straight
    // into the shifter, so the buffer only captures mid-word accepts.
    assign hold_wr = accept && (state == SHIFT) && !cnt_last;
    assign hold_rd = (state == SHIFT) && cnt_last && hold_valid;

    piso_hold #(.WIDTH(WIDTH)) u_hold (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (hold_wr),
        .wr_data    (bus.data_in),
        .rd_en      (hold_rd),
        .rd_data    (hold_data),
        .hold_valid (hold_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            sreg        <= '0;
            cnt         <= '0;
            word_done_r <= 1'b0;
        end else begin
            word_done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sreg  <= bus.data_in;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sreg <= sreg >> 1;
                    cnt  <= cnt + 1'b1;
                    if (cnt_last) begin
                        word_done_r <= 1'b1;
                        if (hold_valid) begin
                            sreg <= hold_data;
                            cnt  <= '0;
                        end else if (accept) begin
                            sreg <= bus.data_in;
                            cnt  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Decoded straight from the state register so a reset drops the link
    // immediately rather than on the next edge.
    assign bus.shift_en  = (state == SHIFT);
    assign bus.ser_out   = (state == SHIFT) && sreg[0];
    assign bus.busy      = (state == SHIFT) || hold_valid;
    assign bus.word_done = word_done_r;

endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed self-checking bench for piso_tx with a 4-bit receiver
module tb_piso_tx;
    import piso_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rx = 4'h0;
    int         total = 0;
    int         bad = 0;
    logic [3:0] word;

    piso_tx_if #(.WIDTH(4)) bus ();

    piso_tx #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Receiver: shifts in at its MSB, moving data toward bit 0.
    always @(posedge clk) begin
        if (bus.shift_en) rx <= {bus.ser_out, rx[3:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.load_valid = 1'b0;
        bus.data_in = 4'h0;
        #2;
        chk1("rst_shift_en", bus.shift_en, 1'b0);
        chk1("rst_ser_out", bus.ser_out, 1'b0);
        chk1("rst_busy", bus.busy, 1'b0);
        chk1("rst_word_done", bus.word_done, 1'b0);
        chk1("rst_load_ready", bus.load_ready, 1'b1);
        bus.load_valid = 1'b1;
        bus.data_in = 4'h7;
        tick();
        chk1("rst_no_accept", bus.shift_en, 1'b0);
        bus.load_valid = 1'b0;
        rst = 1'b0;
        tick();

        // Single word 1011.
        word = 4'b1011;
        bus.load_valid = 1'b1;
        bus.data_in = word;
        tick();
        bus.load_valid = 1'b0;
        chk1("single_busy", bus.busy, 1'b1);
        chk1("single_ready", bus.load_ready, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk1("single_ser", bus.ser_out, word[k]);
            chk1("single_en", bus.shift_en, 1'b1);
            chk1("single_wd_low", bus.word_done, 1'b0);
            tick();
        end
        chk4("single_rx", rx, 4'b1011);
        chk1("single_wd", bus.word_done, 1'b1);
        chk1("single_en_off", bus.shift_en, 1'b0);
        chk1("single_idle_busy", bus.busy, 1'b0);
        tick();
        chk1("single_wd_end", bus.word_done, 1'b0);

        // Back-to-back 5 then A: 1,0,1,0,0,1,0,1 continuous.
        bus.load_valid = 1'b1;
        bus.data_in = 4'h5;
        tick();
        bus.data_in = 4'hA;
        for (int k = 0; k < 8; k++) begin
            word = (k < 4) ? 4'h5 : 4'hA;
            chk1("b2b_ser", bus.ser_out, word[k % 4]);
            chk1("b2b_en", bus.shift_en, 1'b1);
            chk1("b2b_wd", bus.word_done, k == 4);
            if (k == 4) chk4("b2b_rx_first", rx, 4'h5);
            tick();
            if (k == 0) bus.load_valid = 1'b0;
        end
        chk4("b2b_rx_second", rx, 4'hA);
        chk1("b2b_wd_last", bus.word_done, 1'b1);
        chk1("b2b_en_off", bus.shift_en, 1'b0);
        tick();

        // Backpressure: 1, 2, 3 offered continuously.
        bus.load_valid = 1'b1;
        bus.data_in = 4'h1;
        tick();
        chk1("bp_ready_e0", bus.load_ready, 1'b1);
        bus.data_in = 4'h2;
        tick();
        bus.data_in = 4'h3;
        for (int k = 1; k < 4; k++) begin
            chk1("bp_ready_low", bus.load_ready, 1'b0);
            tick();
        end
        chk1("bp_ready_refill", bus.load_ready, 1'b1);
        chk4("bp_rx_1", rx, 4'h1);
        chk1("bp_wd_1", bus.word_done, 1'b1);
        tick();
        bus.load_valid = 1'b0;
        chk1("bp_ready_full", bus.load_ready, 1'b0);
        chk1("bp_busy", bus.busy, 1'b1);
        tick(); tick(); tick();
        chk4("bp_rx_2", rx, 4'h2);
        chk1("bp_wd_2", bus.word_done, 1'b1);
        chk1("bp_en_2", bus.shift_en, 1'b1);
        tick(); tick(); tick(); tick();
        chk4("bp_rx_3", rx, 4'h3);
        chk1("bp_wd_3", bus.word_done, 1'b1);
        chk1("bp_en_off", bus.shift_en, 1'b0);
        chk1("bp_busy_off", bus.busy, 1'b0);
        tick();

        // Last-edge bypass: 6 in flight, C offered only on its final-bit edge.
        bus.load_valid = 1'b1;
        bus.data_in = 4'h6;
        tick();
        bus.load_valid = 1'b0;
        tick(); tick(); tick();
        bus.load_valid = 1'b1;
        bus.data_in = 4'hC;
        tick();
        bus.load_valid = 1'b0;
        chk4("byp_rx_6", rx, 4'h6);
        chk1("byp_wd", bus.word_done, 1'b1);
        chk1("byp_en", bus.shift_en, 1'b1);
        chk1("byp_hold_empty", bus.load_ready, 1'b1);
        word = 4'hC;
        chk1("byp_ser", bus.ser_out, word[0]);
        for (int k = 1; k < 4; k++) begin
            tick();
            chk1("byp_ser", bus.ser_out, word[k]);
            chk1("byp_en", bus.shift_en, 1'b1);
        end
        tick();
        chk4("byp_rx_c", rx, 4'hC);
        chk1("byp_wd_c", bus.word_done, 1'b1);
        chk1("byp_en_off", bus.shift_en, 1'b0);
        tick();

        // Mid-word reset: F shifting two bits, 6 pending.
        bus.load_valid = 1'b1;
        bus.data_in = 4'hF;
        tick();
        bus.data_in = 4'h6;
        tick();
        bus.load_valid = 1'b0;
        tick();
        chk1("mid_busy_pre", bus.busy, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("mid_en_async", bus.shift_en, 1'b0);
        chk1("mid_ser", bus.ser_out, 1'b0);
        chk1("mid_busy", bus.busy, 1'b0);
        chk1("mid_ready", bus.load_ready, 1'b1);
        tick();
        rst = 1'b0;
        chk1("mid_wd_0", bus.word_done, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk1("mid_wd_none", bus.word_done, 1'b0);
            chk1("mid_en_idle", bus.shift_en, 1'b0);
        end
        word = 4'h9;
        bus.load_valid = 1'b1;
        bus.data_in = word;
        tick();
        bus.load_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk1("post_ser", bus.ser_out, word[k]);
            chk1("post_en", bus.shift_en, 1'b1);
            tick();
        end
        chk4("post_rx", rx, 4'h9);
        chk1("post_wd", bus.word_done, 1'b1);
        chk1("post_en_off", bus.shift_en, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
